bcd_mod_counter: RTL and testbench
==================================

Name: bcd_mod_counter

Overview:
- Parametrised BCD modulo counter: the generic successor of the fixed 00–59 minute stage.
- Counts on rising edges of a carry-in level and supports manual up/down adjust. Adds parallel load, a one-cycle carry-out pulse and a one-cycle borrow-out pulse.
- Stages chain directly (carry_out → CARRY of next stage) to build seconds, minutes, hours or day counters from one block.

Parameters:
- DIGITS, 2, number of BCD digits; data width = 4*DIGITS; legal range 1..4.
- MODULUS, 60, count range 0..MODULUS-1; legal range 2..10^DIGITS.
- INIT, 0, binary value loaded on reset; must be < MODULUS.

Ports:
- CP, input, 1: clock; all state updates on rising edge.
- RST, input, 1: synchronous, active-high reset.
- CARRY, input, 1: count-up request; level input, acted on at its rising edge.
- CH, input, 1: manual adjust request; level input, acted on at its rising edge.
- ADJMODE, input, 1: adjust direction, sampled at the CH edge; 0 = +1, 1 = −1.
- LOAD, input, 1: parallel load strobe; level input, acted on in every cycle it is high.
- load_data, input, 4*DIGITS: BCD load value.
- data, output, 4*DIGITS: current count in BCD; digit 0 in bits [3:0].
- carry, output, 1: one-cycle pulse on up-wrap (MODULUS-1 → 0).
- borrow, output, 1: one-cycle pulse on down-wrap (0 → MODULUS-1).
- load_err, output, 1: one-cycle pulse when a LOAD is rejected.

Behaviour:
- Reset (RST=1 at CP edge): data = BCD(INIT); carry = borrow = load_err = 0; both edge-detect registers cleared to 0.
- The first rising edge after reset is therefore seen if CARRY or CH is already high in the first post-reset cycle.
- Edge detection: the previous-cycle values of CARRY and CH are registered. An event occurs when the input is 1 now and was 0 in the previous cycle. Holding an input high produces exactly one step.
- Priority per cycle, highest first: RST > LOAD > CARRY edge > CH edge.
  - A lower-priority event in the same cycle is discarded, not queued.
  - The edge registers still update in that cycle.
- LOAD is accepted when every digit of load_data is ≤ 9 and its value is < MODULUS.
  - Accepted: data = load_data next cycle; no carry or borrow.
  - Rejected: data is unchanged and load_err pulses for 1 cycle.
- CARRY edge: increment. If data == MODULUS-1, data becomes 0 and carry pulses for 1 cycle; otherwise data = data+1.
- CH edge with ADJMODE=0: identical to a CARRY edge, including the carry pulse. The adjust chain ripples into the next stage.
- CH edge with ADJMODE=1: decrement. If data == 0, data becomes MODULUS-1 and borrow pulses for 1 cycle; otherwise data = data−1.
- BCD arithmetic:
  - Increment: a digit at 9 rolls to 0 and the next digit increments.
  - Decrement: a digit at 0 rolls to 9 and the next digit decrements.
  - The modulus check is applied on the whole value, not per digit (e.g. MODULUS=24: 23 → 00, 19 → 20, 20 → 19).
- Latency: data, carry and borrow change on the CP edge that samples the event (one registered stage). Pulses are high exactly one cycle.
- carry, borrow and load_err are 0 in every cycle without their triggering event.
- Reset mid-operation: RST overrides any simultaneous event; no pulse is emitted in the reset cycle.
- Illegal parameters (MODULUS > 10^DIGITS, INIT ≥ MODULUS) stop elaboration via a generate-time check.
- Expected implementation size: 150–250 lines; no multi-cycle state beyond the count and the edge registers.

Test Plan:
- DIGITS=2, MODULUS=60, INIT=0.
  - Apply 60 CARRY rising edges (high 1 cycle, low 1 cycle) → data steps 0x00..0x59 → 0x00; carry high for exactly 1 cycle, on the 0x59 → 0x00 step only.
  - Hold CARRY high for 10 cycles → data increments once only.
- MODULUS=60, data=0x00: CH edge with ADJMODE=1 → data=0x59, borrow pulse 1 cycle, carry stays 0. Next CH edge with ADJMODE=1 → 0x58. At data=0x50, a down-step → 0x49.
- MODULUS=24: load 0x19 then one CARRY edge → 0x20. Load 0x23 then one CARRY edge → 0x00 with carry pulse. Load 0x25 → load_err pulse, data stays 0x00. Load 0x1A → load_err pulse.
- Simultaneous events, MODULUS=60, data=0x10:
  - CARRY and CH rising in the same cycle with ADJMODE=1 → data=0x11; the CH request is dropped.
  - LOAD=1 with load_data=0x30 and a CARRY edge in the same cycle → data=0x30, no increment.
- Chain two instances (MODULUS=60, then MODULUS=24), first stage starting at 0x59:
  - One CARRY edge → stage 1 = 0x00, stage 2 increments by 1 one cycle later.
  - Assert RST in the same cycle as a CARRY edge → both stages read INIT and no pulses occur.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - parametrised BCD modulo counter with load, carry and borrow pulses
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60,
  parameter int INIT    = 0
) (
  input  logic                  CP,
  input  logic                  RST,
  input  logic                  CARRY,
  input  logic                  CH,
  input  logic                  ADJMODE,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   data,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // 10^n, used for the elaboration-time range check
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Binary integer to packed BCD, digit 0 in the low nibble
  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

  // Packed BCD to binary; only meaningful when every digit is <= 9
  function automatic int bcd_value(input logic [W-1:0] v);
    int acc;
    acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  // True when every nibble holds a decimal digit
  function automatic logic digits_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // BCD +1 with digit-to-digit ripple; wrap at the modulus is handled by the caller
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   dig;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = v[4*i +: 4];
      if (c) begin
        if (dig == 4'd9) begin
          dig = 4'd0;
        end else begin
          dig = dig + 4'd1;
          c   = 1'b0;
        end
      end
      r[4*i +: 4] = dig;
    end
    return r;
  endfunction

  // BCD -1 with digit-to-digit borrow; the 0 case is handled by the caller
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   dig;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = v[4*i +: 4];
      if (b) begin
        if (dig == 4'd0) begin
          dig = 4'd9;
        end else begin
          dig = dig - 4'd1;
          b   = 1'b0;
        end
      end
      r[4*i +: 4] = dig;
    end
    return r;
  endfunction

  localparam int            RANGE    = pow10(DIGITS);
  localparam logic [W-1:0]  INIT_BCD = to_bcd(INIT);
  localparam logic [W-1:0]  MAX_BCD  = to_bcd(MODULUS - 1);

  // Refuse to build with parameters that cannot be represented
  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $error("bcd_mod_counter: DIGITS must be 1..4");
    end
    if (MODULUS < 2 || MODULUS > RANGE) begin : g_bad_modulus
      $error("bcd_mod_counter: MODULUS must be 2..10^DIGITS");
    end
    if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
      $error("bcd_mod_counter: INIT must be below MODULUS");
    end
  endgenerate

  logic [W-1:0] data_q,     data_d;
  logic         carry_q,    carry_d;
  logic         borrow_q,   borrow_d;
  logic         load_err_q, load_err_d;
  logic         carry_in_q;
  logic         ch_in_q;

  logic         carry_evt;
  logic         ch_evt;
  logic         load_ok;

  assign carry_evt = CARRY & ~carry_in_q;
  assign ch_evt    = CH & ~ch_in_q;
  assign load_ok   = digits_valid(load_data) && (bcd_value(load_data) < MODULUS);

  // Next count and pulses; LOAD beats a CARRY edge, which beats a CH edge
  always_comb begin
    data_d     = data_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (LOAD) begin
      if (load_ok) data_d = load_data;
      else         load_err_d = 1'b1;
    end else if (carry_evt || (ch_evt && !ADJMODE)) begin
      if (data_q == MAX_BCD) begin
        data_d  = '0;
        carry_d = 1'b1;
      end else begin
        data_d = bcd_inc(data_q);
      end
    end else if (ch_evt) begin
      if (data_q == '0) begin
        data_d   = MAX_BCD;
        borrow_d = 1'b1;
      end else begin
        data_d = bcd_dec(data_q);
      end
    end
  end

  // Count, pulse and edge-history registers; edge history updates even when an event is dropped
  always_ff @(posedge CP) begin
    if (RST) begin
      data_q     <= INIT_BCD;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      carry_in_q <= 1'b0;
      ch_in_q    <= 1'b0;
    end else begin
      data_q     <= data_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
      carry_in_q <= CARRY;
      ch_in_q    <= CH;
    end
  end

  assign data     = data_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - self-checking bench for bcd_mod_counter
module tb_bcd_mod_counter;

  logic cp = 1'b0;
  always #5 cp = ~cp;

  // modulo-60 instance
  logic       rst60 = 1'b1, c60 = 1'b0, ch60 = 1'b0, adj60 = 1'b0, ld60 = 1'b0;
  logic [7:0] ldd60 = 8'h00;
  logic [7:0] d60;
  logic       co60, bo60, le60;

  // modulo-24 instance
  logic       rst24 = 1'b1, c24 = 1'b0, ch24 = 1'b0, adj24 = 1'b0, ld24 = 1'b0;
  logic [7:0] ldd24 = 8'h00;
  logic [7:0] d24;
  logic       co24, bo24, le24;

  // chained pair: 60 -> 24
  logic       rstc = 1'b1, cc = 1'b0, ldc = 1'b0;
  logic [7:0] lddc = 8'h00;
  logic [7:0] dc1, dc2;
  logic       coc1, boc1, lec1, coc2, boc2, lec2;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .INIT(0)) u60 (
    .CP(cp), .RST(rst60), .CARRY(c60), .CH(ch60), .ADJMODE(adj60), .LOAD(ld60),
    .load_data(ldd60), .data(d60), .carry(co60), .borrow(bo60), .load_err(le60));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .INIT(0)) u24 (
    .CP(cp), .RST(rst24), .CARRY(c24), .CH(ch24), .ADJMODE(adj24), .LOAD(ld24),
    .load_data(ldd24), .data(d24), .carry(co24), .borrow(bo24), .load_err(le24));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .INIT(0)) uc1 (
    .CP(cp), .RST(rstc), .CARRY(cc), .CH(1'b0), .ADJMODE(1'b0), .LOAD(ldc),
    .load_data(lddc), .data(dc1), .carry(coc1), .borrow(boc1), .load_err(lec1));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .INIT(0)) uc2 (
    .CP(cp), .RST(rstc), .CARRY(coc1), .CH(1'b0), .ADJMODE(1'b0), .LOAD(1'b0),
    .load_data(8'h00), .data(dc2), .carry(coc2), .borrow(boc2), .load_err(lec2));

  typedef struct {
    int         sel;
    logic       rst, carry, ch, adj, load;
    logic [7:0] ld;
    logic [7:0] e_data;
    logic       e_c, e_b, e_le;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   vec_no = 0;

  function automatic vec_t mk(int sel, logic rst, logic carry, logic ch, logic adj, logic load,
                              logic [7:0] ld, logic [7:0] ed, logic ec, logic eb, logic ele);
    vec_t v;
    v.sel = sel; v.rst = rst; v.carry = carry; v.ch = ch; v.adj = adj; v.load = load;
    v.ld = ld; v.e_data = ed; v.e_c = ec; v.e_b = eb; v.e_le = ele;
    return v;
  endfunction

  task automatic chk(input string what, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step%0d: got %h, expected %h", what, idx, act, exp);
    end
  endtask

  // drive one cycle of stimulus, push its expectation, pop and compare after the edge
  task automatic apply(input vec_t v);
    vec_t       e;
    logic [7:0] ad;
    logic       ac, ab, al;
    if (v.sel == 0) begin
      rst60 = v.rst; c60 = v.carry; ch60 = v.ch; adj60 = v.adj; ld60 = v.load; ldd60 = v.ld;
    end else begin
      rst24 = v.rst; c24 = v.carry; ch24 = v.ch; adj24 = v.adj; ld24 = v.load; ldd24 = v.ld;
    end
    sb.push_back(v);
    @(posedge cp);
    #1;
    e = sb.pop_front();
    if (e.sel == 0) begin
      ad = d60; ac = co60; ab = bo60; al = le60;
    end else begin
      ad = d24; ac = co24; ab = bo24; al = le24;
    end
    chk(e.sel == 0 ? "m60.data" : "m24.data", vec_no, ad, e.e_data);
    chk(e.sel == 0 ? "m60.carry" : "m24.carry", vec_no, {7'd0, ac}, {7'd0, e.e_c});
    chk(e.sel == 0 ? "m60.borrow" : "m24.borrow", vec_no, {7'd0, ab}, {7'd0, e.e_b});
    chk(e.sel == 0 ? "m60.load_err" : "m24.load_err", vec_no, {7'd0, al}, {7'd0, e.e_le});
    vec_no++;
  endtask

  // integer reference for count-up runs on the modulo-60 instance
  int   m_cnt = 0;
  logic m_pc  = 1'b0;

  task automatic model_step(input logic rst, input logic carry);
    logic ce, co;
    co = 1'b0;
    if (rst) begin
      m_cnt = 0;
      m_pc  = 1'b0;
    end else begin
      ce = carry & ~m_pc;
      if (ce) begin
        co    = (m_cnt == 59);
        m_cnt = (m_cnt + 1) % 60;
      end
      m_pc = carry;
    end
    apply(mk(0, rst, carry, 1'b0, 1'b0, 1'b0, 8'h00,
             {4'(m_cnt / 10), 4'(m_cnt % 10)}, co, 1'b0, 1'b0));
  endtask

  task automatic chain_cycle(input logic rst, input logic carry, input logic load, input logic [7:0] ld);
    rstc = rst; cc = carry; ldc = load; lddc = ld;
    @(posedge cp);
    #1;
  endtask

  task automatic chain_chk(input int idx, input logic [7:0] e1, input logic [7:0] e2,
                           input logic ec1, input logic ec2);
    chk("chain.s1", idx, dc1, e1);
    chk("chain.s2", idx, dc2, e2);
    chk("chain.s1carry", idx, {7'd0, coc1}, {7'd0, ec1});
    chk("chain.s2carry", idx, {7'd0, coc2}, {7'd0, ec2});
    chk("chain.borrows", idx, {6'd0, boc1, boc2}, 8'h00);
  endtask

  initial begin
    // sel rst carry ch adj load ld   -> data c b le
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h59, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h59, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h58, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h58, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h50, 8'h50, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h49, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 8'h00, 8'h11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'h30, 8'h30, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h30, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h30, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h31, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h31, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h59, 8'h59, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h5A, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h60, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h20, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h45, 8'h45, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h46, 8'h46, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h09, 8'h09, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h19, 8'h19, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'h00, 8'h19, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h19, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h23, 8'h23, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h25, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h1A, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'h00, 8'h23, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h23, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // full modulo-60 sweep: 60 one-cycle CARRY pulses
    model_step(1'b1, 1'b0);
    model_step(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      model_step(1'b0, 1'b1);
      model_step(1'b0, 1'b0);
    end

    // CARRY held high for 10 cycles steps once
    for (int i = 0; i < 10; i++) model_step(1'b0, 1'b1);
    model_step(1'b0, 1'b0);
    model_step(1'b0, 1'b0);

    // chained stages: stage-1 wrap ripples into stage 2 one cycle later
    chain_cycle(1'b1, 1'b0, 1'b0, 8'h00);  chain_chk(0, 8'h00, 8'h00, 1'b0, 1'b0);
    chain_cycle(1'b0, 1'b0, 1'b1, 8'h59);  chain_chk(1, 8'h59, 8'h00, 1'b0, 1'b0);
    chain_cycle(1'b0, 1'b1, 1'b0, 8'h00);  chain_chk(2, 8'h00, 8'h00, 1'b1, 1'b0);
    chain_cycle(1'b0, 1'b0, 1'b0, 8'h00);  chain_chk(3, 8'h00, 8'h01, 1'b0, 1'b0);
    chain_cycle(1'b0, 1'b0, 1'b1, 8'h59);  chain_chk(4, 8'h59, 8'h01, 1'b0, 1'b0);
    // reset coinciding with a CARRY edge wins; no pulse anywhere
    chain_cycle(1'b1, 1'b1, 1'b0, 8'h00);  chain_chk(5, 8'h00, 8'h00, 1'b0, 1'b0);
    chain_cycle(1'b0, 1'b0, 1'b0, 8'h00);  chain_chk(6, 8'h00, 8'h00, 1'b0, 1'b0);
    chain_cycle(1'b0, 1'b0, 1'b0, 8'h00);  chain_chk(7, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
